// File: rtl/wb_la_arbiter.sv
// Round-robin arbiter: Wishbone slave and LA requester share one device port.
// Define WB_LA_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES.
module wb_la_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_req_i,
  input  logic        la_we_i,
  input  logic [31:0] la_adr_i,
  input  logic [31:0] la_wdata_i,
  output logic        la_gnt_o,
  output logic        la_rvalid_o,
  output logic [31:0] la_rdata_o,
  output logic        dev_req_o,
  output logic        dev_we_o,
  output logic [3:0]  dev_be_o,
  output logic [31:0] dev_addr_o,
  output logic [31:0] dev_wdata_o,
  input  logic        dev_gnt_i,
  input  logic        dev_rvalid_i,
  input  logic [31:0] dev_rdata_i,
  output logic        arb_busy_o,
  output logic [7:0]  tmo_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        own_wb_q, own_wb_d;
  logic        last_wb_q, last_wb_d;
  logic        abort_q, abort_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] wbdat_q, wbdat_d;
  logic [31:0] ladat_q, ladat_d;

  logic        wb_req, pick_wb, pick_la;
  logic        in_txn, done;
  logic [31:0] rdata;

  assign wb_req  = wbs_cyc_i & wbs_stb_i;
  assign pick_wb = wb_req & (~la_req_i | ~last_wb_q);
  assign pick_la = la_req_i & ~pick_wb;
  assign in_txn  = (state_q == REQ) || (state_q == WAIT);

`ifdef WB_LA_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic       tmo_hit;

  assign tmo_hit = in_txn && (8'(cnt_q + 8'd1) == TMO) &&
                   !((state_q == WAIT) && dev_rvalid_i);
  assign tmo_cnt_o = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_cnt_o = 8'd0;
`endif

  always_comb begin
    state_d   = state_q;
    own_wb_d  = own_wb_q;
    last_wb_d = last_wb_q;
    abort_d   = abort_q;
    we_d      = we_q;
    be_d      = be_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    wbdat_d   = wbdat_q;
    ladat_d   = ladat_q;
    done      = 1'b0;
    rdata     = dev_rdata_i;
    unique case (state_q)
      IDLE: begin
        if (pick_wb || pick_la) begin
          state_d   = REQ;
          own_wb_d  = pick_wb;
          last_wb_d = pick_wb;
          abort_d   = 1'b0;
          we_d      = pick_wb ? wbs_we_i  : la_we_i;
          be_d      = pick_wb ? wbs_sel_i : 4'hF;
          adr_d     = pick_wb ? wbs_adr_i : la_adr_i;
          wdat_d    = pick_wb ? wbs_dat_i : la_wdata_i;
        end
      end
      REQ:  if (dev_gnt_i) state_d = WAIT;
      WAIT: begin
        if (dev_rvalid_i) begin
          state_d = RESP;
          done    = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An abandoned WB cycle still runs to completion on the device
    if (in_txn && own_wb_q && !wbs_cyc_i) abort_d = 1'b1;
`ifdef WB_LA_ARB_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = RESP;
      done    = 1'b1;
      rdata   = 32'hDEADBEEF;
    end
`endif
    if (done) begin
      if (own_wb_q) wbdat_d = rdata;
      else          ladat_d = rdata;
    end
  end

`ifdef WB_LA_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = in_txn ? 8'(cnt_q + 8'd1) : 8'd0;
    tmo_d = tmo_q;
    if (tmo_hit && tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= 8'd0;
      tmo_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      own_wb_q  <= 1'b0;
      last_wb_q <= 1'b0;
      abort_q   <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      adr_q     <= 32'h0;
      wdat_q    <= 32'h0;
      wbdat_q   <= 32'h0;
      ladat_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      own_wb_q  <= own_wb_d;
      last_wb_q <= last_wb_d;
      abort_q   <= abort_d;
      we_q      <= we_d;
      be_q      <= be_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      wbdat_q   <= wbdat_d;
      ladat_q   <= ladat_d;
    end
  end

  assign dev_req_o   = (state_q == REQ);
  assign dev_we_o    = we_q;
  assign dev_be_o    = be_q;
  assign dev_addr_o  = adr_q;
  assign dev_wdata_o = wdat_q;
  assign arb_busy_o  = (state_q != IDLE);
  assign wbs_ack_o   = (state_q == RESP) & own_wb_q & ~abort_q;
  assign la_rvalid_o = (state_q == RESP) & ~own_wb_q;
  assign wbs_dat_o   = wbdat_q;
  assign la_rdata_o  = ladat_q;
  // Gated by reset so the combinational capture pulse is 0 while held in reset
  assign la_gnt_o    = wb_rst_ni & (state_q == IDLE) & pick_la;

endmodule

// File: tb/tb_wb_la_arbiter.sv
// Directed bench for wb_la_arbiter: vector table plus multi-cycle sequences.
module tb_wb_la_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] wb_rdat;
  logic        lreq, lwe;
  logic [31:0] ladr, lwd;
  logic        lgnt, lrv;
  logic [31:0] lrd;
  logic        dreq, dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr, dwd;
  logic        gnt, rv;
  logic [31:0] rd;
  logic        busy;
  logic [7:0]  tmo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_la_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(wb_rdat),
    .la_req_i(lreq), .la_we_i(lwe), .la_adr_i(ladr), .la_wdata_i(lwd),
    .la_gnt_o(lgnt), .la_rvalid_o(lrv), .la_rdata_o(lrd),
    .dev_req_o(dreq), .dev_we_o(dwe), .dev_be_o(dbe),
    .dev_addr_o(daddr), .dev_wdata_o(dwd),
    .dev_gnt_i(gnt), .dev_rvalid_i(rv), .dev_rdata_i(rd),
    .arb_busy_o(busy), .tmo_cnt_o(tmo)
  );

  typedef struct {
    logic        cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic        lreq, lwe;
    logic [31:0] ladr, lwd;
    logic        gnt, rv;
    logic [31:0] rd;
    logic [4:0]  eflg;
    logic [31:0] edat, eldat, eaddr, ewd;
    logic        ewe;
    logic [3:0]  ebe;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t v(
    logic c, logic w, logic [3:0] s, logic [31:0] a,
    logic lr, logic lw, logic [31:0] la, logic [31:0] ld,
    logic g, logic r, logic [31:0] d,
    logic [4:0] ef, logic [31:0] ed, logic [31:0] eld,
    logic [31:0] ea, logic [31:0] ewdat, logic ew, logic [3:0] eb);
    vec_t x;
    x.cyc = c; x.we = w; x.sel = s; x.adr = a;
    x.lreq = lr; x.lwe = lw; x.ladr = la; x.lwd = ld;
    x.gnt = g; x.rv = r; x.rd = d;
    x.eflg = ef; x.edat = ed; x.eldat = eld;
    x.eaddr = ea; x.ewd = ewdat; x.ewe = ew; x.ebe = eb;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 0; wdat = 0;
    lreq = 0; lwe = 0; ladr = 0; lwd = 0;
    gnt = 0; rv = 0; rd = 0;
  endtask

  task automatic wb_on(logic [31:0] a, logic [3:0] s);
    cyc = 1; stb = 1; we = 0; adr = a; sel = s;
  endtask

  localparam logic [31:0] WA = 32'h3000_0010;
  localparam logic [31:0] LD = 32'hA5A5_A5A5;

  initial begin
    int n;
    logic ok;
    tbl[0]  = v(1,0,4'hF,WA, 0,0,0,0,       0,0,0,
                5'b00000, 0, 0, 0, 0, 0, 4'h0);
    tbl[1]  = v(1,0,4'hF,WA, 0,0,0,0,       1,0,0,
                5'b00011, 0, 0, WA, 0, 0, 4'hF);
    tbl[2]  = v(1,0,4'hF,WA, 0,0,0,0,       0,1,32'h1234_5678,
                5'b00001, 0, 0, 0, 0, 0, 4'h0);
    tbl[3]  = v(1,0,4'hF,WA, 0,0,0,0,       0,0,0,
                5'b10001, 32'h1234_5678, 0, 0, 0, 0, 4'h0);
    tbl[4]  = v(0,0,4'h0,0,  0,0,0,0,       0,0,0,
                5'b00000, 32'h1234_5678, 0, 0, 0, 0, 4'h0);
    tbl[5]  = v(0,0,4'h0,0,  1,1,32'h100,LD, 0,0,0,
                5'b01000, 32'h1234_5678, 0, 0, 0, 0, 4'h0);
    tbl[6]  = v(0,0,4'h0,0,  0,0,0,0,       0,0,0,
                5'b00011, 32'h1234_5678, 0, 32'h100, LD, 1, 4'hF);
    tbl[7]  = v(0,0,4'h0,0,  0,0,0,0,       0,1,32'hFFFF_0000,
                5'b00011, 32'h1234_5678, 0, 32'h100, LD, 1, 4'hF);
    tbl[8]  = v(0,0,4'h0,0,  0,0,0,0,       1,0,0,
                5'b00011, 32'h1234_5678, 0, 32'h100, LD, 1, 4'hF);
    tbl[9]  = v(0,0,4'h0,0,  0,0,0,0,       0,1,32'h1111_0000,
                5'b00001, 32'h1234_5678, 0, 0, 0, 0, 4'h0);
    tbl[10] = v(0,0,4'h0,0,  0,0,0,0,       0,0,0,
                5'b00101, 32'h1234_5678, 32'h1111_0000, 0, 0, 0, 4'h0);
    tbl[11] = v(0,0,4'h0,0,  0,0,0,0,       0,0,0,
                5'b00000, 32'h1234_5678, 32'h1111_0000, 0, 0, 0, 4'h0);

    idle_in();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dreq", 32'(dreq), 0);
    chk("rst_tmo", 32'(tmo), 0);
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      cyc = tbl[i].cyc; stb = tbl[i].cyc; we = tbl[i].we;
      sel = tbl[i].sel; adr = tbl[i].adr;
      lreq = tbl[i].lreq; lwe = tbl[i].lwe;
      ladr = tbl[i].ladr; lwd = tbl[i].lwd;
      gnt = tbl[i].gnt; rv = tbl[i].rv; rd = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i),
          32'({ack, lgnt, lrv, dreq, busy}), 32'(tbl[i].eflg));
      chk($sformatf("vec%0d_wbdat", i), wb_rdat, tbl[i].edat);
      chk($sformatf("vec%0d_ladat", i), lrd, tbl[i].eldat);
      if (tbl[i].eflg[1]) begin
        chk($sformatf("vec%0d_addr", i), daddr, tbl[i].eaddr);
        chk($sformatf("vec%0d_wdata", i), dwd, tbl[i].ewd);
        chk($sformatf("vec%0d_we_be", i), 32'({dwe, dbe}),
            32'({tbl[i].ewe, tbl[i].ebe}));
      end
      tick();
    end
    idle_in();

    // WB drops cyc while waiting: device completes, no ack
    wb_on(32'h3000_0040, 4'hF);
    tick();
    gnt = 1;
    tick();
    gnt = 0; cyc = 0; stb = 0;
    tick();
    rv = 1; rd = 32'h0000_0055;
    tick();
    rv = 0;
    @(negedge clk);
    chk("drop_ack", 32'(ack), 0);
    chk("drop_busy_resp", 32'(busy), 1);
    tick();
    @(negedge clk);
    chk("drop_busy_after", 32'(busy), 0);
    tick();

`ifdef WB_LA_ARB_TIMEOUT_EN
    wb_on(32'h3000_0080, 4'hF);
    tick();
    n = 20;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack) begin
        n = k;
        break;
      end
      tick();
    end
    chk("tmo_latency", 32'(n), 8);
    chk("tmo_data", wb_rdat, 32'hDEAD_BEEF);
    chk("tmo_dreq", 32'(dreq), 0);
    chk("tmo_cnt", 32'(tmo), 1);
    tick();
    idle_in();
    tick();
`else
    wb_on(32'h3000_0080, 4'hF);
    tick();
    ok = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!dreq || !busy || ack || tmo != 0) ok = 0;
      tick();
    end
    chk("no_tmo_hold", 32'(ok), 1);
    chk("no_tmo_cnt", 32'(tmo), 0);
    gnt = 1;
    tick();
    gnt = 0; rv = 1; rd = 32'h0000_0077;
    tick();
    rv = 0;
    @(negedge clk);
    chk("no_tmo_ack", 32'(ack), 1);
    chk("no_tmo_dat", wb_rdat, 32'h0000_0077);
    tick();
    idle_in();
    tick();
`endif

    // Reset in WAIT clears everything at once
    wb_on(32'h3000_0100, 4'hF);
    tick();
    gnt = 1;
    tick();
    gnt = 0; lreq = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_flags", 32'({ack, lgnt, lrv, dreq, busy}), 0);
    chk("arst_dev", 32'({dwe, dbe}) | daddr | dwd, 0);
    chk("arst_wbdat", wb_rdat, 0);
    chk("arst_ladat", lrd, 0);
    chk("arst_tmo", 32'(tmo), 0);
    idle_in();
    tick();
    tick();
    rst_n = 1;
    rv = 1; rd = 32'h0BAD_0BAD;
    ok = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack || busy || lrv) ok = 0;
      tick();
    end
    rv = 0;
    chk("stray_rvalid", 32'(ok), 1);

    // Tie from reset: WB first, then LA in the IDLE after WB's RESP
    wb_on(32'h3000_0020, 4'h3);
    lreq = 1; ladr = 32'h400;
    @(negedge clk);
    chk("tie_lgnt0", 32'(lgnt), 0);
    tick();
    gnt = 1;
    @(negedge clk);
    chk("tie_wb_addr", daddr, 32'h3000_0020);
    chk("tie_wb_be", 32'(dbe), 32'h3);
    tick();
    gnt = 0; rv = 1; rd = 32'hCAFE_0001;
    tick();
    rv = 0;
    @(negedge clk);
    chk("tie_wb_ack", 32'({ack, lgnt}), 32'b10);
    chk("tie_wb_dat", wb_rdat, 32'hCAFE_0001);
    tick();
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("tie_lgnt1", 32'(lgnt), 1);
    tick();
    lreq = 0; gnt = 1;
    @(negedge clk);
    chk("tie_la_addr", daddr, 32'h400);
    chk("tie_la_be", 32'(dbe), 32'hF);
    tick();
    gnt = 0; rv = 1; rd = 32'hBEEF_0002;
    tick();
    rv = 0;
    @(negedge clk);
    chk("tie_la_rv", 32'({ack, lrv}), 32'b01);
    chk("tie_la_dat", lrd, 32'hBEEF_0002);
    tick();
    @(negedge clk);
    chk("tie_idle", 32'(busy), 0);

    // Both held back-to-back: owners alternate
    wb_on(32'h600, 4'hF);
    lreq = 1; ladr = 32'h500;
    @(negedge clk);
    chk("b2b_lgnt0", 32'(lgnt), 0);
    tick();
    gnt = 1;
    tick();
    gnt = 0; rv = 1; rd = 32'h1;
    tick();
    rv = 0;
    @(negedge clk);
    chk("b2b_wb_ack", 32'(ack), 1);
    tick();
    @(negedge clk);
    chk("b2b_lgnt1", 32'(lgnt), 1);
    tick();
    lreq = 0; gnt = 1;
    @(negedge clk);
    chk("b2b_la_addr", daddr, 32'h500);
    tick();
    gnt = 0; rv = 1; rd = 32'h2;
    tick();
    rv = 0;
    @(negedge clk);
    chk("b2b_la_rv", 32'(lrv), 1);
    tick();
    @(negedge clk);
    chk("b2b_wb_again", 32'(lgnt), 0);
    tick();
    @(negedge clk);
    chk("b2b_wb_addr", daddr, 32'h600);
    gnt = 1;
    tick();
    gnt = 0; rv = 1; rd = 32'h3;
    tick();
    rv = 0;
    @(negedge clk);
    chk("b2b_wb_ack2", 32'(ack), 1);
    tick();
    idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_la_arbiter.md
WB_LA_ARBITER -- requirements
Module: wb_la_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles allowed in REQ+WAIT before forced completion (legal range 1..255).
REQ-002 wb_clk_i  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-005 wbs_sel_i  input  4  byte select; wbs_adr_i  input  32  address; wbs_dat_i  input  32  write data.
REQ-006 wbs_ack_o  output  1  one-cycle acknowledge; wbs_dat_o  output  32  read data.
REQ-007 la_req_i, la_we_i  input  1 each  LA requester level request and write-enable; la_adr_i, la_wdata_i  input  32 each.
REQ-008 la_gnt_o  output  1  one-cycle capture pulse; la_rvalid_o  output  1  one-cycle completion; la_rdata_o  output  32.
REQ-009 dev_req_o, dev_we_o  output  1 each; dev_be_o  output  4; dev_addr_o, dev_wdata_o  output  32 each  shared device port.
REQ-010 dev_gnt_i, dev_rvalid_i  input  1 each; dev_rdata_i  input  32  device grant, completion, read data.
REQ-011 arb_busy_o  output  1  high whenever state is not IDLE; tmo_cnt_o  output  8  saturating timeout count.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-013 WB request SHALL be wbs_cyc_i & wbs_stb_i; LA request SHALL be la_req_i.
REQ-014 In IDLE with one request, that requester SHALL be captured; with both, the requester not served last SHALL be captured (round-robin; last-owner resets to LA, so WB wins first tie).
REQ-015 On capture: address, write data, we, and be (wbs_sel_i for WB, 4'hF for LA) SHALL be registered; state -> REQ; la_gnt_o SHALL pulse in the capture cycle when LA is captured.
REQ-016 dev_req_o SHALL equal (state==REQ); dev_addr_o/dev_wdata_o/dev_we_o/dev_be_o SHALL be the registered values and stable while dev_req_o is high.
REQ-017 REQ -> WAIT on dev_gnt_i; WAIT -> RESP on dev_rvalid_i, capturing dev_rdata_i (reads and writes both complete via dev_rvalid_i).
REQ-018 dev_rvalid_i is not sampled while in REQ; dev_rvalid_i outside WAIT SHALL be ignored.
REQ-019 RESP SHALL last exactly one cycle then -> IDLE; wbs_ack_o pulses in RESP iff owner is WB, la_rvalid_o iff owner is LA.
REQ-020 wbs_dat_o and la_rdata_o SHALL hold the last captured read data for their requester until the next completion for that requester.
REQ-021 Minimum latency: request sampled cycle 0, dev_req_o cycle 1, dev_gnt_i cycle 1, dev_rvalid_i cycle 2, ack/rvalid cycle 3.
REQ-022 If WB owner drops wbs_cyc_i during REQ/WAIT, the device transaction SHALL complete normally and wbs_ack_o SHALL be suppressed in RESP.
REQ-023 Back-to-back: a request held through RESP SHALL be arbitrated in the following IDLE cycle; round-robin SHALL then favour the other requester if both pending.

Reset
REQ-024 Asserting wb_rst_ni low SHALL immediately force state IDLE, last-owner LA, all outputs 0 (dev_*_o, wbs_ack_o, wbs_dat_o, la_gnt_o, la_rvalid_o, la_rdata_o, arb_busy_o, tmo_cnt_o), regardless of an in-flight transaction.
REQ-025 After deassertion, the first arbitration SHALL occur on the first rising edge with wb_rst_ni high.

Configuration
REQ-026 Macro WB_LA_ARB_TIMEOUT_EN defined: a cycle counter SHALL count cycles in REQ+WAIT; on reaching TIMEOUT_CYCLES the FSM SHALL go to RESP with read data 32'hDEADBEEF, drop dev_req_o, and increment tmo_cnt_o (saturates at 255).
REQ-027 Macro undefined: no timeout; REQ/WAIT SHALL wait indefinitely; tmo_cnt_o SHALL be constant 0.

Verification
REQ-028 WB read 0x30000010, device gnt same cycle, rvalid next cycle with 0x12345678 -> wbs_ack_o one pulse at cycle 3, wbs_dat_o=0x12345678.
REQ-029 WB and LA request in same cycle from reset -> WB served first, LA second; la_gnt_o pulses in IDLE after WB RESP.
REQ-030 LA write 0xA5A5A5A5 to 0x100 -> dev_be_o=4'hF, dev_we_o=1, dev_wdata_o stable until dev_gnt_i, la_rvalid_o one pulse.
REQ-031 WB read, drop wbs_cyc_i in WAIT -> device completes, no wbs_ack_o, arb_busy_o low after RESP.
REQ-032 WB_LA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, dev_gnt_i never asserted -> ack at 8 cycles after REQ entry, wbs_dat_o=0xDEADBEEF, tmo_cnt_o=1.
REQ-033 wb_rst_ni low during WAIT -> all outputs 0 same cycle; later stray dev_rvalid_i produces no ack.
